// File: rtl/irq_controller.sv
// Interrupt controller: edge-detects peripheral requests into PEND, masks them and
// presents one registered IRQ to the CPU, tracking the in-service source until return.
module irq_controller #(
    parameter int          NSRC      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic            kernel,
    input  logic            irq_ack,
    input  logic            irq_ret,
    output logic            irq,
    output logic [2:0]      irq_id
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state, state_n;
    logic [NSRC-1:0] pend, mask, src_q;
    logic            ge;
    logic [NSRC-1:0] events, req_vec, bus_clr, ack_clr, pend_n;
    logic [2:0]      sel;
    logic            hit, take_ack, in_service;
    logic [1:0]      off;
    logic            unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

    // The window is 16-byte aligned, so the upper 28 address bits select it.
    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign off     = addr[3:2];
    assign events  = src & ~src_q;
    assign req_vec = pend & mask;

    always_comb begin
        sel = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_vec[i]) sel = 3'(i);
        end
    end

    // Clears are applied first so a same-cycle event always wins.
    assign bus_clr = (wr && hit && off == 2'd0) ? wdata[NSRC-1:0] : '0;
    assign ack_clr = take_ack ? ({{(NSRC-1){1'b0}}, 1'b1} << sel) : '0;
    assign pend_n  = (pend & ~(bus_clr | ack_clr)) | events;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pend   <= '0;
            mask   <= '0;
            ge     <= 1'b0;
            src_q  <= '0;
            irq    <= 1'b0;
            irq_id <= 3'd0;
        end else begin
            state <= state_n;
            src_q <= src;
            pend  <= pend_n;
            irq   <= (state_n == REQ);
            if (wr && hit && off == 2'd1) mask <= wdata[NSRC-1:0];
            if (wr && hit && off == 2'd3) ge <= wdata[0];
            if (take_ack) irq_id <= sel;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ge && |req_vec && !kernel) state_n = REQ;
            REQ: begin
                if (irq_ack) state_n = SERVICE;
                else if (!ge || req_vec == '0 || kernel) state_n = IDLE;
            end
            SERVICE: if (irq_ret) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        take_ack   = (state == REQ) && irq_ack;
        in_service = (state == SERVICE);
    end

    always_comb begin
        rdata = 32'd0;
        if (rd && hit) begin
            case (off)
                2'd0: rdata = {{(32-NSRC){1'b0}}, pend};
                2'd1: rdata = {{(32-NSRC){1'b0}}, mask};
                2'd2: rdata = {28'd0, in_service, irq_id};
                2'd3: rdata = {31'd0, ge};
                default: rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller between the on-chip peripherals (timer, UART RX/TX, switches) and the CPU's single IRQ input.
- Latches source events into a pending register and applies a mask and a global enable.
- Presents one registered IRQ request to the control unit and tracks the in-service interrupt until the handler returns.
- Memory-mapped on the peripheral bus (addr[30] space) so software can mask, acknowledge and inspect interrupts.

Parameters:
NSRC, 4, number of interrupt sources (1..8); source 0 has highest priority.
BASE_ADDR, 32'h40000030, word-aligned base of the 4-word register window.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
src  input  NSRC  source request levels; a rising edge raises an event
rd  input  1  bus read strobe
wr  input  1  bus write strobe
addr  input  32  bus byte address
wdata  input  32  bus write data
rdata  output  32  bus read data, combinational
kernel  input  1  CPU in kernel mode (PC[31]); no interrupt is taken while 1
irq_ack  input  1  one-cycle pulse: CPU vectors to ILLOP this cycle
irq_ret  input  1  one-cycle pulse: CPU executes return from the handler (jr $26 in kernel)
irq  output  1  registered interrupt request to Control
irq_id  output  3  index of the in-service source; valid in SERVICE

Behaviour:
- Reset (async, reset==0):
  - PEND=0, MASK=0, GE=0, src_q=0, state=IDLE, irq=0, irq_id=0.
  - Reset mid-service drops to IDLE with no further handshake.
- Edge detect:
  - src_q <= src every edge.
  - Event on bit i when src[i] & ~src_q[i]; PEND[i] is set at that same edge.
- Register map (offset from BASE_ADDR, word-addressed):
  - 0x0 PEND: read = pending bits. Write-1-to-clear. If set and clear hit the same bit in the same cycle, set wins.
  - 0x4 MASK: read/write, NSRC bits; 1 = enabled.
  - 0x8 STAT: read-only = {28'b0, in_service, irq_id}; writes ignored.
  - 0xC CTRL: bit0 = GE (global enable), read/write.
- Bus reads and writes:
  - rdata is 0 when rd==0 or addr is outside the window. Unused upper bits read 0.
  - A write takes effect at the clock edge when wr==1.
- Request terms:
  - req_vec = PEND & MASK.
  - sel = lowest set index of req_vec.
- FSM:
  - IDLE, irq=0: go to REQ when GE & |req_vec & ~kernel.
  - REQ, irq=1:
    - If irq_ack: go to SERVICE, irq_id<=sel, clear PEND[sel] (unless a new event sets it in the same cycle), irq<=0.
    - Else if ~GE, or req_vec==0, or kernel: withdraw to IDLE, irq<=0.
    - irq_ack takes priority over withdrawal in the same cycle.
  - SERVICE, irq=0, in_service=1: go to IDLE on irq_ret. New events keep accumulating in PEND. No nesting.
  - irq_ack outside REQ and irq_ret outside SERVICE are ignored.
- Latency:
  - src sampled high at edge k (src_q=0): PEND set after edge k, irq high after edge k+1, assuming idle, enabled, user mode.
  - After irq_ret at edge m with work still pending: IDLE after m, irq high again after m+1 if still in user mode.
- irq is a flop output and never glitches; irq_id holds its value until the next acknowledge.

Test Plan:
1. Reset, MASK=4'b0010, CTRL=1; pulse src[1] at edge 10 -> PEND=4'b0010 after edge 10, irq=1 after edge 11; irq_ack -> irq=0, STAT=0x9, PEND=0.
2. src[3] and src[1] rise together, MASK=4'hF -> first ack gives irq_id=1 and PEND=4'b1000; irq_ret -> irq high again 2 edges later; second ack gives irq_id=3.
3. Pending src[2] with kernel=1 -> irq stays 0; kernel drops to 0 -> irq=1 one edge later; raise kernel before ack -> irq withdraws to 0 next edge, PEND[2] still 1.
4. In REQ, write CTRL=0 (GE cleared) -> irq=0 next edge; write PEND=4'b0100 while src[2] rises in the same cycle -> PEND[2] remains 1.
5. Bus check: read 0xC after reset -> 0; read an address outside the window -> rdata=0; write STAT -> STAT unchanged; src held high for many cycles -> exactly one PEND set.
6. Assert reset in SERVICE -> immediately IDLE, irq=0, irq_id=0, all registers 0; irq_ret after reset has no effect.
